// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write scheduler.
// The register file itself has no reset, so the scheduler zero-fills it after reset or flush.
package rf_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_DBG  = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_write_sched_arb.sv
// Combinational round-robin arbiter.
// The search starts one past ptr. gnt is one-hot, or all-zero when req is all-zero.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);

  int  idx;
  logic found;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_sched.sv
// Drives the single register-file write port.
// It zero-fills registers 1..31 after reset or flush, then grants writeback requesters round-robin.
module regfile_write_sched
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               RegWrite,
  output logic [AW-1:0]      write_reg,
  output logic [DW-1:0]      write_data,
  output logic               init_busy
);

  localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(RF_NREGS - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            we_q, we_d;
  logic [AW-1:0]   wreg_q, wreg_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            handshake;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Ready is masked during zero-fill and during flush, so no handshake can complete then.
  assign req_ready = (state_q == RUN && !flush) ? gnt : '0;
  assign handshake = |(req_valid & req_ready);
  assign sel_addr  = req_addr[int'(gnt_idx)*AW +: AW];
  assign sel_data  = req_data[int'(gnt_idx)*DW +: DW];

  assign init_busy  = (state_q == CLEAR);
  assign RegWrite   = we_q;
  assign write_reg  = wreg_q;
  assign write_data = wdata_q;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    rr_ptr_d  = rr_ptr_q;
    we_d      = 1'b0;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    if (flush) begin
      state_d   = CLEAR;
      clr_idx_d = AW'(1);
    end else begin
      unique case (state_q)
        CLEAR: begin
          we_d      = 1'b1;
          wreg_d    = clr_idx_q;
          wdata_d   = '0;
          clr_idx_d = clr_idx_q + AW'(1);
          if (clr_idx_q == LAST_IDX) state_d = RUN;
        end
        RUN: begin
          if (handshake) begin
            rr_ptr_d = gnt_idx;
            // Writes to register 0 are accepted but never reach the register file.
            if (sel_addr != '0) begin
              we_d    = 1'b1;
              wreg_d  = sel_addr;
              wdata_d = sel_data;
            end
          end
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= AW'(1);
      rr_ptr_q  <= PW'(NREQ - 1);
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed plus randomized bench for regfile_write_sched.
// The behavioural model tracks fill progress and the last-served requester.
module tb_regfile_write_sched;
  import rf_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = RF_AW;
  localparam int DW   = RF_DW;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               reg_write;
  logic [AW-1:0]      write_reg;
  logic [DW-1:0]      write_data;
  logic               init_busy;

  int total = 0;
  int bad   = 0;

  // Model state
  bit          m_clear;
  int          m_idx;
  int          m_ptr;
  bit          m_we;
  int          m_reg;
  logic [31:0] m_data;
  int          last_g;

  logic [AW-1:0] a [NREQ];
  logic [DW-1:0] d [NREQ];
  bit            pend [NREQ];

  regfile_write_sched #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .RegWrite   (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .init_busy  (init_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_clear = 1'b1; m_idx = 1; m_ptr = NREQ - 1;
    m_we = 1'b0; m_reg = 0; m_data = '0;
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  endtask

  function automatic int model_grant();
    if (m_clear || flush) return -1;
    for (int k = 1; k <= NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  // Called just after a negedge with inputs already driven; returns just after the next negedge.
  task automatic tick(input string tag);
    logic [NREQ-1:0] exp_rdy;
    pack_inputs();
    #1;
    last_g  = model_grant();
    exp_rdy = '0;
    if (last_g >= 0) exp_rdy[last_g] = 1'b1;
    check({tag, ".ready"}, 64'(req_ready), 64'(exp_rdy));
    check({tag, ".busy"}, 64'(init_busy), 64'(m_clear));
    if (flush) begin
      m_clear = 1'b1; m_idx = 1; m_we = 1'b0;
    end else if (m_clear) begin
      m_we = 1'b1; m_reg = m_idx; m_data = '0;
      if (m_idx == RF_NREGS - 1) m_clear = 1'b0;
      m_idx++;
    end else if (last_g >= 0) begin
      m_ptr = last_g;
      m_we  = (a[last_g] != 0);
      if (m_we) begin m_reg = a[last_g]; m_data = d[last_g]; end
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk); #1;
    check({tag, ".we"}, 64'(reg_write), 64'(m_we));
    if (m_we) begin
      check({tag, ".wreg"}, 64'(write_reg), 64'(m_reg));
      check({tag, ".wdata"}, 64'(write_data), 64'(m_data));
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit v, input int addr, input logic [31:0] data);
    req_valid[i] = v; a[i] = AW'(addr); d[i] = data;
  endtask

  task automatic idle();
    req_valid = '0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin a[i] = '0; d[i] = '0; pend[i] = 1'b0; end
    pack_inputs();
    model_reset();
    #12;
    check("reset.we", 64'(reg_write), 64'(0));
    check("reset.wreg", 64'(write_reg), 64'(0));
    check("reset.wdata", 64'(write_data), 64'(0));
    check("reset.ready", 64'(req_ready), 64'(0));
    check("reset.busy", 64'(init_busy), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // 1: zero-fill of registers 1..31, with a requester waiting that must not be granted
    set_req(REQ_ALU, 1'b1, 7, 32'h1111_1111);
    for (int c = 0; c < RF_NREGS - 1; c++) tick("fill");
    check("fill.done_busy", 64'(init_busy), 64'(0));
    idle();
    tick("idle");

    // 2: single ALU write
    set_req(REQ_ALU, 1'b1, 5, 32'hDEAD_BEEF);
    tick("single");
    check("single.reg5", 64'(write_reg), 64'(5));
    check("single.data", 64'(write_data), 64'(32'hDEAD_BEEF));
    idle();
    tick("single_idle");

    // 3: move pointer to 2, then all three valid continuously -> 0,1,2,0,1,2
    set_req(REQ_DBG, 1'b1, 3, 32'h0000_0003);
    tick("ptr2");
    idle();
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8 + 4*c + i, 32'hA000_0000 + 32'(16*c + i));
      tick("rr");
      check("rr.order", 64'(last_g), 64'(c % NREQ));
    end
    idle();
    tick("rr_idle");

    // 4: load requester writes register 0 -> accepted, discarded
    set_req(REQ_LOAD, 1'b1, 0, 32'h0000_1234);
    tick("zero_addr");
    check("zero_addr.ptr", 64'(m_ptr), 64'(REQ_LOAD));
    idle();
    // pointer now 1: with 1 and 2 valid, 2 wins
    set_req(REQ_LOAD, 1'b1, 9, 32'h9); set_req(REQ_DBG, 1'b1, 10, 32'hA);
    tick("after_zero");
    check("after_zero.grant", 64'(last_g), 64'(REQ_DBG));
    idle();

    // 5: flush during fill cycle 10, restarting the fill; first a flush out of RUN
    flush = 1'b1;
    set_req(REQ_ALU, 1'b1, 4, 32'h4);
    tick("flush_run");
    idle();
    for (int c = 0; c < 9; c++) tick("fill_a");
    flush = 1'b1;
    tick("flush_clear");
    flush = 1'b0;
    for (int c = 0; c < RF_NREGS - 1; c++) tick("fill_b");
    check("fill_b.busy", 64'(init_busy), 64'(0));

    // 6: async reset while a write is pending
    set_req(REQ_DBG, 1'b1, 17, 32'h5555_AAAA);
    pack_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check("async.we", 64'(reg_write), 64'(0));
    check("async.busy", 64'(init_busy), 64'(1));
    check("async.ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    check("async.we_held", 64'(reg_write), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle();
    for (int c = 0; c < RF_NREGS - 1; c++) tick("fill_c");

    // Randomized traffic with occasional flush; pending requests stay stable until accepted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i]) set_req(i, bit'($urandom_range(0, 1)), $urandom_range(0, RF_NREGS - 1), $urandom);
      flush = ($urandom_range(0, 39) == 0);
      tick("rand");
      for (int i = 0; i < NREQ; i++) pend[i] = req_valid[i] && (last_g != i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
